// File: rtl/rr_arbiter_4_if.sv
// ============================================================================
// Module  : rr_arbiter_4_if
// Brief   : Request/grant bundle between four requesters and rr_arbiter_4.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_arbiter_4_if;
  logic       EN;
  logic [3:0] REQ;
  logic [3:0] GNT;
  logic [1:0] GNT_ID;
  logic       GNT_VALID;
  logic       TIMEOUT;

  modport master (
    output EN, REQ,
    input  GNT, GNT_ID, GNT_VALID, TIMEOUT
  );

  modport slave (
    input  EN, REQ,
    output GNT, GNT_ID, GNT_VALID, TIMEOUT
  );
endinterface

`default_nettype wire

// File: rtl/rr_arbiter_4.sv
// ============================================================================
// Module  : rr_arbiter_4
// Brief   : Four-way round-robin arbiter driving a one-hot grant and its index.
//           Optional hold-timeout revoke enabled by macro RR_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_4 #(
  parameter int MAX_HOLD  = 16,
  parameter int RESET_PTR = 0
) (
  input  wire logic         clk,
  input  wire logic         rst,
  rr_arbiter_4_if.slave     bus
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state,   w_state_nxt;
  logic [1:0] r_ptr,     w_ptr_nxt;
  logic [1:0] r_gnt_id,  w_gnt_id_nxt;
  logic [3:0] r_gnt,     w_gnt_nxt;
  logic       r_timeout, w_timeout_nxt;
  logic [1:0] w_rel_ptr;
  logic [1:0] w_win_idle;
  logic [1:0] w_win_rel;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int c_hold_w = $clog2(MAX_HOLD + 1);
  logic [c_hold_w-1:0] r_hold_cnt, w_hold_cnt_nxt;
`else
  logic w_unused_max_hold;
  assign w_unused_max_hold = (MAX_HOLD >= 2);
`endif

  // First requester at or after 'start', wrapping mod 4; lowest offset wins.
  function automatic logic [1:0] f_winner(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] win;
    win = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

  assign w_rel_ptr  = r_gnt_id + 2'd1;
  assign w_win_idle = f_winner(bus.REQ, r_ptr);
  assign w_win_rel  = f_winner(bus.REQ, w_rel_ptr);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'(RESET_PTR);
      r_gnt_id   <= 2'd0;
      r_gnt      <= 4'd0;
      r_timeout  <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_gnt      <= w_gnt_nxt;
      r_timeout  <= w_timeout_nxt;
`ifdef RR_ARB_TIMEOUT_EN
      r_hold_cnt <= w_hold_cnt_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_id_nxt  = r_gnt_id;
    w_gnt_nxt     = r_gnt;
    w_timeout_nxt = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    w_hold_cnt_nxt = r_hold_cnt;
`endif

    if (!bus.EN) begin
      // Pointer and last index survive a disable so arbitration resumes fairly.
      w_gnt_nxt   = 4'd0;
      w_state_nxt = S_IDLE;
`ifdef RR_ARB_TIMEOUT_EN
      w_hold_cnt_nxt = '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|bus.REQ) begin
            w_gnt_nxt    = 4'b0001 << w_win_idle;
            w_gnt_id_nxt = w_win_idle;
            w_state_nxt  = S_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
            w_hold_cnt_nxt = c_hold_w'(1);
`endif
          end
        end
        S_GRANT: begin
          if (bus.REQ[r_gnt_id]) begin
`ifdef RR_ARB_TIMEOUT_EN
            if (r_hold_cnt == c_hold_w'(MAX_HOLD)) begin
              w_gnt_nxt      = 4'd0;
              w_timeout_nxt  = 1'b1;
              w_ptr_nxt      = w_rel_ptr;
              w_state_nxt    = S_IDLE;
              w_hold_cnt_nxt = '0;
            end else begin
              w_hold_cnt_nxt = r_hold_cnt + c_hold_w'(1);
            end
`endif
          end else begin
            // Release: hand off in the same edge when someone else is waiting.
            w_ptr_nxt = w_rel_ptr;
            if (|bus.REQ) begin
              w_gnt_nxt    = 4'b0001 << w_win_rel;
              w_gnt_id_nxt = w_win_rel;
`ifdef RR_ARB_TIMEOUT_EN
              w_hold_cnt_nxt = c_hold_w'(1);
`endif
            end else begin
              w_gnt_nxt   = 4'd0;
              w_state_nxt = S_IDLE;
`ifdef RR_ARB_TIMEOUT_EN
              w_hold_cnt_nxt = '0;
`endif
            end
          end
        end
        default: begin
          w_gnt_nxt   = 4'd0;
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  assign bus.GNT       = r_gnt;
  assign bus.GNT_ID    = r_gnt_id;
  assign bus.GNT_VALID = |r_gnt;
  assign bus.TIMEOUT   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_4.sv
// ============================================================================
// Module  : tb_rr_arbiter_4
// Brief   : Directed self-checking bench for rr_arbiter_4 (MAX_HOLD=4).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(
    .MAX_HOLD  (4),
    .RESET_PTR (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.EN = 1'b1;
    bus.REQ = 4'b1111;
    repeat (3) tick();
    rst = 1'b0;
    bus.REQ = 4'b0000;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (bus.GNT !== 4'b0000) begin n_err++; $display("FAIL reset_gnt: got %b want 0000", bus.GNT); end
    n_cmp++;
    if (bus.GNT_ID !== 2'd0) begin n_err++; $display("FAIL reset_gnt_id: got %0d want 0", bus.GNT_ID); end
    n_cmp++;
    if (bus.GNT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.GNT_VALID); end
    n_cmp++;
    if (bus.TIMEOUT !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", bus.TIMEOUT); end
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b0000) begin n_err++; $display("FAIL idle_no_req: got %b want 0000", bus.GNT); end
  endtask

  task automatic test_single();
    bus.REQ = 4'b0100;
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b0100 || bus.GNT_ID !== 2'd2 || bus.GNT_VALID !== 1'b1) begin
      n_err++; $display("FAIL single_grant: got gnt=%b id=%0d v=%b want 0100/2/1", bus.GNT, bus.GNT_ID, bus.GNT_VALID);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (bus.GNT !== 4'b0100) begin n_err++; $display("FAIL single_hold[%0d]: got %b want 0100", i, bus.GNT); end
    end
    bus.REQ = 4'b0000;
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b0000 || bus.GNT_VALID !== 1'b0 || bus.GNT_ID !== 2'd2) begin
      n_err++; $display("FAIL single_release: got gnt=%b v=%b id=%0d want 0000/0/2", bus.GNT, bus.GNT_VALID, bus.GNT_ID);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_gnt [5];
    logic [1:0] exp_id  [5];
    logic [3:0] drop    [5];
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_id  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    drop    = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.REQ = drop[i];
      tick();
      n_cmp++;
      if (bus.GNT !== exp_gnt[i] || bus.GNT_ID !== exp_id[i]) begin
        n_err++; $display("FAIL rotation[%0d]: got gnt=%b id=%0d want %b/%0d", i, bus.GNT, bus.GNT_ID, exp_gnt[i], exp_id[i]);
      end
    end
    bus.REQ = 4'b0000;
    tick();
  endtask

  task automatic test_skip();
    bus.REQ = 4'b0010;
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b0010) begin n_err++; $display("FAIL skip_owner1: got %b want 0010", bus.GNT); end
    bus.REQ = 4'b1001;
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b1000 || bus.GNT_ID !== 2'd3) begin
      n_err++; $display("FAIL skip_to3: got gnt=%b id=%0d want 1000/3", bus.GNT, bus.GNT_ID);
    end
    bus.REQ = 4'b0001;
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b0001 || bus.GNT_ID !== 2'd0) begin
      n_err++; $display("FAIL skip_to0: got gnt=%b id=%0d want 0001/0", bus.GNT, bus.GNT_ID);
    end
    bus.REQ = 4'b0000;
    tick();
  endtask

  task automatic test_enable_drop();
    bus.REQ = 4'b0100;
    tick();
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b0100) begin n_err++; $display("FAIL en_owner2: got %b want 0100", bus.GNT); end
    bus.EN = 1'b0;
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b0000 || bus.GNT_VALID !== 1'b0 || bus.GNT_ID !== 2'd2) begin
      n_err++; $display("FAIL en_off: got gnt=%b v=%b id=%0d want 0000/0/2", bus.GNT, bus.GNT_VALID, bus.GNT_ID);
    end
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b0000) begin n_err++; $display("FAIL en_off_hold: got %b want 0000", bus.GNT); end
    bus.EN = 1'b1;
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b0100 || bus.GNT_ID !== 2'd2) begin
      n_err++; $display("FAIL en_on: got gnt=%b id=%0d want 0100/2", bus.GNT, bus.GNT_ID);
    end
    bus.REQ = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    logic [3:0] exp_gnt [6];
    logic       exp_to  [6];
`ifdef RR_ARB_TIMEOUT_EN
    exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0010};
    exp_to  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_to  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    do_reset();
    bus.REQ = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++;
      if (bus.GNT !== exp_gnt[i] || bus.TIMEOUT !== exp_to[i]) begin
        n_err++; $display("FAIL timeout[%0d]: got gnt=%b to=%b want %b/%b", i, bus.GNT, bus.TIMEOUT, exp_gnt[i], exp_to[i]);
      end
    end
  endtask

  task automatic test_reset_priority();
    bus.REQ = 4'b1111;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.GNT !== 4'b0000 || bus.GNT_ID !== 2'd0 || bus.TIMEOUT !== 1'b0) begin
      n_err++; $display("FAIL reset_prio: got gnt=%b id=%0d to=%b want 0000/0/0", bus.GNT, bus.GNT_ID, bus.TIMEOUT);
    end
    tick();
    n_cmp++;
    if (bus.GNT !== 4'b0001) begin n_err++; $display("FAIL reset_ptr: got %b want 0001", bus.GNT); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.EN = 1'b0;
    bus.REQ = 4'b0000;
    test_reset();
    test_single();
    test_rotation();
    test_skip();
    test_enable_drop();
    test_timeout();
    test_reset_priority();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
